// File: rtl/comma_aligner_if.sv
// Receive-side bundle between the deserializer front end and the 8b/10b word aligner.
// The master drives the serial bit stream and decoder error flag; the slave returns aligned symbols.
interface comma_aligner_if;
  logic       sin;
  logic       sin_valid;
  logic       code_err;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       comma_det;
  logic       locked;

  modport master (
    output sin,
    output sin_valid,
    output code_err,
    input  sym_out,
    input  sym_valid,
    input  comma_det,
    input  locked
  );

  modport slave (
    input  sin,
    input  sin_valid,
    input  code_err,
    output sym_out,
    output sym_valid,
    output comma_det,
    output locked
  );
endinterface

// File: rtl/comma_aligner.sv
// 8b/10b receive word aligner: hunts for K28.x commas in the serial stream, emits aligned
// 10-bit symbols, confirms lock over repeated aligned commas and drops it on decoder errors.
module comma_aligner #(
  parameter int LOCK_CNT  = 3,
  parameter int ERR_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  comma_aligner_if.slave rx
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] ERR_TGT  = 4'(ERR_LIMIT);

  state_t     state_q, state_d;
  logic [9:0] sr_q, sr_n;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [9:0] sym_out_q;
  logic       sym_valid_q;
  logic       comma_det_q;
  logic       locked_q;
  logic       comma_match;
  logic       complete;
  logic       emit;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // The window is judged on the shift register as it will look after this bit lands.
  always_comb begin
    sr_n        = {sr_q[8:0], rx.sin};
    comma_match = rx.sin_valid && ((sr_n[9:3] == 7'b0011111) || (sr_n[9:3] == 7'b1100000));
    complete    = rx.sin_valid && (bit_cnt_q == 4'd9);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    emit       = 1'b0;

    if (rx.sin_valid) begin
      bit_cnt_d = complete ? 4'd0 : bit_cnt_q + 4'd1;
      unique case (state_q)
        HUNT: begin
          if (comma_match) begin
            emit       = 1'b1;
            bit_cnt_d  = 4'd0;
            good_cnt_d = 4'd1;
            state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end

        VERIFY: begin
          if (complete) begin
            emit = 1'b1;
            if (comma_match) begin
              good_cnt_d = sat_inc(good_cnt_q);
              if (good_cnt_d >= LOCK_TGT) state_d = LOCKED;
            end
          end else if (comma_match) begin
            emit       = 1'b1;
            bit_cnt_d  = 4'd0;
            good_cnt_d = 4'd1;
          end
          if (rx.code_err) begin
            state_d    = HUNT;
            good_cnt_d = 4'd0;
            err_cnt_d  = 4'd0;
          end
        end

        LOCKED: begin
          if (complete) begin
            emit = 1'b1;
            if (comma_match) err_cnt_d = 4'd0;
          end
          // A comma landing with an error still counts that error against the fresh budget.
          if (rx.code_err) begin
            err_cnt_d = (complete && comma_match) ? 4'd1 : sat_inc(err_cnt_q);
            if (err_cnt_d >= ERR_TGT) begin
              state_d    = HUNT;
              good_cnt_d = 4'd0;
              err_cnt_d  = 4'd0;
              emit       = 1'b0;
            end
          end
        end

        default: begin
          state_d    = HUNT;
          good_cnt_d = 4'd0;
          err_cnt_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      comma_det_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      good_cnt_q  <= good_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sym_valid_q <= emit;
      locked_q    <= (state_d == LOCKED);
      if (rx.sin_valid) sr_q <= sr_n;
      if (emit) begin
        sym_out_q   <= sr_n;
        comma_det_q <= comma_match;
      end
    end
  end

  assign rx.sym_out   = sym_out_q;
  assign rx.sym_valid = sym_valid_q;
  assign rx.comma_det = comma_det_q;
  assign rx.locked    = locked_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: table of bit chunks with expected symbol outputs,
// plus hand-written sequences for random gaps and mid-symbol reset.
module tb_comma_aligner;

  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D215 = 10'b1010101010;
  localparam logic [9:0] D102 = 10'b0101010101;

  typedef struct {
    logic [9:0] bits;
    int         len;
    int         err_pos;
    logic       exp_valid;
    logic [9:0] exp_sym;
    logic       exp_comma;
    logic       exp_locked;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t vecs[$];

  comma_aligner_if bus ();

  comma_aligner #(.LOCK_CNT(3), .ERR_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [9:0] act, input logic [9:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic apply_stimulus(input logic b, input logic v, input logic e);
    bus.sin       = b;
    bus.sin_valid = v;
    bus.code_err  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [9:0] bits, input int len, input int err_pos,
                         input logic exp_valid, input logic [9:0] exp_sym,
                         input logic exp_comma, input logic exp_locked);
    vec_t v;
    v.bits = bits; v.len = len; v.err_pos = err_pos;
    v.exp_valid = exp_valid; v.exp_sym = exp_sym;
    v.exp_comma = exp_comma; v.exp_locked = exp_locked;
    vecs.push_back(v);
  endtask

  task automatic run_rows(input int first, input int last);
    vec_t v;
    for (int i = first; i <= last; i++) begin
      v = vecs[i];
      for (int b = v.len - 1; b >= 0; b--) begin
        apply_stimulus(v.bits[b], 1'b1, (v.len - 1 - b) == v.err_pos);
        if (b != 0) check_output($sformatf("row%0d_mid_valid", i), {9'b0, bus.sym_valid}, 10'd0);
      end
      check_output($sformatf("row%0d_valid", i), {9'b0, bus.sym_valid}, {9'b0, v.exp_valid});
      check_output($sformatf("row%0d_locked", i), {9'b0, bus.locked}, {9'b0, v.exp_locked});
      if (v.exp_valid) begin
        check_output($sformatf("row%0d_sym", i), bus.sym_out, v.exp_sym);
        check_output($sformatf("row%0d_comma", i), {9'b0, bus.comma_det}, {9'b0, v.exp_comma});
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_sym"}, bus.sym_out, 10'd0);
    check_output({name, "_valid"}, {9'b0, bus.sym_valid}, 10'd0);
    check_output({name, "_comma"}, {9'b0, bus.comma_det}, 10'd0);
    check_output({name, "_locked"}, {9'b0, bus.locked}, 10'd0);
  endtask

  initial begin
    logic [9:0] sym;
    logic       stray;
    bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.code_err = 1'b0;

    // Rows 0..12: acquisition from reset through lock.
    add_vec(10'b000, 3, -1, 1'b0, 10'd0, 1'b0, 1'b0);
    add_vec(K285, 10, -1, 1'b1, K285, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add_vec(D215, 10, -1, 1'b1, D215, 1'b0, 1'b0);
    add_vec(K285, 10, -1, 1'b1, K285, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add_vec(D215, 10, -1, 1'b1, D215, 1'b0, 1'b0);
    add_vec(K285, 10, -1, 1'b1, K285, 1'b1, 1'b1);
    add_vec(D215, 10, -1, 1'b1, D215, 1'b0, 1'b1);
    // Rows 13..19: error budget refreshed by an aligned comma.
    for (int i = 0; i < 3; i++) add_vec(D215, 10, 2, 1'b1, D215, 1'b0, 1'b1);
    add_vec(K285, 10, -1, 1'b1, K285, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add_vec(D215, 10, 2, 1'b1, D215, 1'b0, 1'b1);
    // Rows 20..23: fourth error drops lock the next cycle, silence until a new comma.
    add_vec(10'b101, 3, 2, 1'b0, 10'd0, 1'b0, 1'b0);
    add_vec(10'b0101010, 7, -1, 1'b0, 10'd0, 1'b0, 1'b0);
    add_vec(D215, 10, -1, 1'b0, 10'd0, 1'b0, 1'b0);
    add_vec(K285, 10, -1, 1'b1, K285, 1'b1, 1'b0);
    // Rows 24..31: comma shifted 4 bits early realigns, lock needs two more commas.
    add_vec(D215, 10, -1, 1'b1, D215, 1'b0, 1'b0);
    add_vec(10'b101010, 6, -1, 1'b0, 10'd0, 1'b0, 1'b0);
    add_vec(10'b0011, 4, -1, 1'b1, 10'b1010100011, 1'b0, 1'b0);
    add_vec(10'b111010, 6, -1, 1'b1, K285, 1'b1, 1'b0);
    add_vec(D215, 10, -1, 1'b1, D215, 1'b0, 1'b0);
    add_vec(K285, 10, -1, 1'b1, K285, 1'b1, 1'b0);
    add_vec(D215, 10, -1, 1'b1, D215, 1'b0, 1'b0);
    add_vec(K285, 10, -1, 1'b1, K285, 1'b1, 1'b1);

    reset = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    check_all_zero("reset");

    run_rows(0, vecs.size() - 1);

    // Locked stream with random sin_valid gaps must deliver every symbol unchanged.
    for (int s = 0; s < 200; s++) begin
      sym = (s % 5 == 0) ? K285 : ((s % 2 == 1) ? D215 : D102);
      stray = 1'b0;
      for (int b = 9; b >= 0; b--) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 9) < 3) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (bus.sym_valid) stray = 1'b1;
          end
        end
        apply_stimulus(sym[b], 1'b1, 1'b0);
        if (b != 0 && bus.sym_valid) stray = 1'b1;
      end
      check_output($sformatf("gap%0d_stray", s), {9'b0, stray}, 10'd0);
      check_output($sformatf("gap%0d_sym", s),
                   {bus.sym_out[9:1] ^ {9{~bus.sym_valid}}, bus.sym_out[0]}, sym);
      check_output($sformatf("gap%0d_comma_locked", s), {8'b0, bus.comma_det, bus.locked},
                   {8'b0, (s % 5 == 0), 1'b1});
    end

    // Reset mid-symbol while locked, with coincident sin_valid and code_err.
    for (int b = 9; b >= 5; b--) apply_stimulus(D215[b], 1'b1, 1'b0);
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    check_all_zero("midreset");
    run_rows(0, 12);

    bus.sin_valid = 1'b0;
    bus.code_err  = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/comma_aligner.md
# comma_aligner

Serial-to-symbol word aligner for the 8b/10b receive path. Takes the recovered serial bit stream one bit per qualified clock. Hunts for the K28.x comma pattern to find symbol boundaries, then emits aligned 10-bit symbols to the 6b/5b and 4b/3b decoders. Confirms lock with repeated aligned commas and drops lock on excessive decoder code errors.

## Interface
- LOCK_CNT, 3, consecutive aligned commas needed to assert lock (range 1..15)
- ERR_LIMIT, 4, decoder code errors without an intervening aligned comma that force loss of sync (range 1..15)

- clk  in  1  receive clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sin  in  1  serial data bit; transmit order a,b,c,d,e,i,f,g,h,j
- sin_valid  in  1  qualifies sin; when low, all state holds
- code_err  in  1  OR of downstream decoder code-error flags, one pulse per bad symbol
- sym_out  out  10  aligned symbol; [9]=a … [4]=i, [3:0]=fghj (4b/3b decoder input)
- sym_valid  out  1  one-cycle pulse, sym_out valid
- comma_det  out  1  qualifies sym_out as containing a comma, valid with sym_valid
- locked  out  1  alignment confirmed

## Operation
- Shift register sr[9:0] updates on sin_valid: sr_n = {sr[8:0], sin}. The oldest bit sits at [9].
- comma_match = sin_valid and sr_n[9:3] ∈ {0011111, 1100000}.
- bit_cnt (0..9) counts bits of the current symbol already received. A symbol is complete when sin_valid and bit_cnt==9.
- Emit: sym_out<=sr_n, sym_valid<=1, comma_det<=comma_match, bit_cnt<=0.
- HUNT: no emission. On comma_match, emit, set good_cnt<=1, go to VERIFY. If LOCK_CNT==1, go directly to LOCKED.
- VERIFY:
  - Complete symbol: emit. If it is a comma, good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - comma_match with bit_cnt!=9 (misaligned): realign. Emit that window, bit_cnt<=0, good_cnt<=1.
  - code_err: go to HUNT (no emission that cycle beyond a coincident complete symbol).
- LOCKED:
  - Complete symbol: emit. Misaligned commas are ignored.
  - Aligned comma clears err_cnt.
  - code_err increments err_cnt. If comma and code_err coincide, err_cnt<=1.
  - When err_cnt reaches ERR_LIMIT, go to HUNT and clear good_cnt and err_cnt.
- Exiting LOCKED or VERIFY to HUNT does not flush sr. Hunting resumes on the next bit.
- Counters are 4 bits and saturate; they never wrap.

## Timing
- All outputs are registered.
- Reset values: sym_out=0, sym_valid=0, comma_det=0, locked=0, sr=0, bit_cnt=0, good_cnt=0, err_cnt=0, state=HUNT.
- Reset takes priority over sin_valid and code_err in the same cycle.
- Reset mid-symbol discards the partial symbol. The first output after reset requires a fresh comma.
- Latency: sym_valid rises the cycle after the clock that sampled the symbol's j bit.
- With continuous sin_valid, sym_valid pulses every 10 cycles.
- locked rises in the same cycle as the sym_valid of the LOCK_CNT-th aligned comma.
- locked falls the cycle after the code_err that reaches ERR_LIMIT. No sym_valid is produced from that cycle until the next comma.
- sin_valid low: sym_valid=0 that cycle and all counters and state are held. Gaps of any length do not affect alignment.

## Test plan
- Reset, then 3 filler bits, then K28.5 RD- (0011111010), then D21.5 (1010101010) continuous → sym_valid one cycle after the 13th bit, sym_out=0011111010, comma_det=1. Next pulse 10 cycles later with sym_out=1010101010, comma_det=0.
- Three aligned K28.5 separated by 4 data symbols → locked=0 through the second comma. locked=1 with the third comma's sym_valid.
- In VERIFY after one comma, inject a comma shifted 4 bits → immediate realign (sym_valid 4 cycles early, comma_det=1). Lock then requires 2 further commas on the new phase.
- LOCKED: pulse code_err 3 times, then an aligned comma, then 3 more pulses → stays locked. A fourth consecutive pulse → locked=0 next cycle and sym_valid stops until a new comma.
- Random sin_valid gaps (about 30% low) over 200 symbols containing periodic commas → symbol sequence identical to the gap-free run and locked stays 1.
- Assert reset for one cycle while LOCKED mid-symbol → all outputs 0 next cycle. Recovery follows the HUNT sequence above.
